// File: rtl/axi_slice_pkg.sv
// Shared types and helpers for the AXI channel register-slice chain.
//   slice_mode_e  : per-chain stage flavour (bypass, forward register, spill register)
//   spill_state_e : fill level of a two-entry spill stage
//   occ_width()   : width of the occupancy counter for a given number of cuts
package axi_slice_pkg;

    typedef enum logic [1:0] {
        SLICE_BYPASS = 2'd0,
        SLICE_FWD    = 2'd1,
        SLICE_SPILL  = 2'd2
    } slice_mode_e;

    typedef enum logic [1:0] {
        SPILL_EMPTY = 2'd0,
        SPILL_ONE   = 2'd1,
        SPILL_TWO   = 2'd2
    } spill_state_e;

    // Enough bits to count up to two entries per cut; never narrower than one bit.
    function automatic int occ_width(input int num_cuts);
        int w;
        w = $clog2(2 * num_cuts + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/axi_chan_slice_stage.sv
// One valid/ready register stage of the channel slice chain.
// Ports:
//   clk, rst         : clock and asynchronous active-high reset
//   valid_i/ready_o  : upstream handshake, data_i payload
//   valid_o/ready_i  : downstream handshake, data_o payload
//   count_o          : number of beats currently held (0..2)
module axi_chan_slice_stage
    import axi_slice_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter slice_mode_e MODE       = SLICE_SPILL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            count_o
);

    generate
        if (MODE == SLICE_FWD) begin : g_fwd
            logic                  r_full;
            logic [DATA_WIDTH-1:0] r_data;
            logic                  w_load;

            // Ready stays combinational: a full entry can accept when it is draining.
            assign ready_o = !r_full || ready_i;
            assign w_load  = valid_i && ready_o;
            assign valid_o = r_full;
            assign data_o  = r_data;
            assign count_o = {1'b0, r_full};

            // A new load wins over the clear of an outgoing beat.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_full <= 1'b0;
                    r_data <= '0;
                end else if (w_load) begin
                    r_full <= 1'b1;
                    r_data <= data_i;
                end else if (ready_i) begin
                    r_full <= 1'b0;
                end
            end
        end else if (MODE == SLICE_SPILL) begin : g_spill
            spill_state_e          r_state;
            spill_state_e          w_stateNext;
            logic [DATA_WIDTH-1:0] r_a;
            logic [DATA_WIDTH-1:0] r_b;
            logic                  w_inHs;
            logic                  w_outHs;
            logic                  w_loadA;
            logic                  w_loadB;
            logic                  w_moveB;

            // Ready comes only from the state register, cutting the ready path.
            assign ready_o = (r_state != SPILL_TWO);
            assign valid_o = (r_state != SPILL_EMPTY);
            assign data_o  = r_a;
            assign w_inHs  = valid_i && ready_o;
            assign w_outHs = valid_o && ready_i;
            assign count_o = (r_state == SPILL_TWO) ? 2'd2 :
                             (r_state == SPILL_ONE) ? 2'd1 : 2'd0;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= SPILL_EMPTY;
                end else begin
                    r_state <= w_stateNext;
                end
            end

            // A is the output register; B only holds the beat that arrived while A was stuck.
            always_comb begin
                w_stateNext = r_state;
                w_loadA     = 1'b0;
                w_loadB     = 1'b0;
                w_moveB     = 1'b0;
                case (r_state)
                    SPILL_EMPTY: begin
                        if (w_inHs) begin
                            w_loadA     = 1'b1;
                            w_stateNext = SPILL_ONE;
                        end
                    end
                    SPILL_ONE: begin
                        if (w_inHs && w_outHs) begin
                            w_loadA = 1'b1;
                        end else if (w_inHs) begin
                            w_loadB     = 1'b1;
                            w_stateNext = SPILL_TWO;
                        end else if (w_outHs) begin
                            w_stateNext = SPILL_EMPTY;
                        end
                    end
                    SPILL_TWO: begin
                        if (w_outHs) begin
                            w_moveB     = 1'b1;
                            w_stateNext = SPILL_ONE;
                        end
                    end
                    default: begin
                        w_stateNext = SPILL_EMPTY;
                    end
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else begin
                    if (w_loadA) begin
                        r_a <= data_i;
                    end else if (w_moveB) begin
                        r_a <= r_b;
                    end
                    if (w_loadB) begin
                        r_b <= data_i;
                    end
                end
            end
        end else begin : g_bypass
            assign ready_o = ready_i;
            assign valid_o = valid_i;
            assign data_o  = data_i;
            assign count_o = 2'd0;
        end
    endgenerate

endmodule

// File: rtl/axi_chan_slice_chain.sv
// Parametrised register-slice chain for one AXI channel.
// Ports:
//   clk, rst           : clock and asynchronous active-high reset
//   valid_i/ready_o    : upstream handshake, data_i payload (ready_o held low in reset)
//   valid_o/ready_i    : downstream handshake, data_o payload
//   occupancy_o        : beats held across all stages
//   idle_o             : high when nothing is held
module axi_chan_slice_chain
    import axi_slice_pkg::*;
#(
    parameter int          DATA_WIDTH = 64,
    parameter int          NUM_CUTS   = 1,
    parameter slice_mode_e MODE       = SLICE_SPILL,
    localparam int         OCC_WIDTH  = occ_width(NUM_CUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [OCC_WIDTH-1:0]  occupancy_o,
    output logic                  idle_o
);

    logic w_readyHead;

    generate
        if (MODE == SLICE_BYPASS || NUM_CUTS == 0) begin : g_bypass
            assign valid_o     = valid_i;
            assign data_o      = data_i;
            assign w_readyHead = ready_i;
            assign occupancy_o = '0;
        end else begin : g_chain
            logic [NUM_CUTS:0]     w_valid;
            logic [NUM_CUTS:0]     w_ready;
            logic [DATA_WIDTH-1:0] w_data  [NUM_CUTS+1];
            logic [1:0]            w_count [NUM_CUTS];
            logic [OCC_WIDTH-1:0]  w_sum;

            assign w_valid[0]        = valid_i;
            assign w_data[0]         = data_i;
            assign w_ready[NUM_CUTS] = ready_i;

            for (genvar k = 0; k < NUM_CUTS; k++) begin : g_stage
                axi_chan_slice_stage #(
                    .DATA_WIDTH(DATA_WIDTH),
                    .MODE      (MODE)
                ) u_stage (
                    .clk    (clk),
                    .rst    (rst),
                    .valid_i(w_valid[k]),
                    .ready_o(w_ready[k]),
                    .data_i (w_data[k]),
                    .valid_o(w_valid[k+1]),
                    .ready_i(w_ready[k+1]),
                    .data_o (w_data[k+1]),
                    .count_o(w_count[k])
                );
            end

            // Occupancy is the plain sum of per-stage entry counts.
            always_comb begin
                w_sum = '0;
                for (int k = 0; k < NUM_CUTS; k++) begin
                    w_sum = w_sum + OCC_WIDTH'(w_count[k]);
                end
            end

            assign valid_o     = w_valid[NUM_CUTS];
            assign data_o      = w_data[NUM_CUTS];
            assign w_readyHead = w_ready[0];
            assign occupancy_o = w_sum;
        end
    endgenerate

    // Upstream never sees ready while the chain is being reset.
    assign ready_o = w_readyHead && !rst;
    assign idle_o  = (occupancy_o == '0);

endmodule

// File: tb/tb_axi_chan_slice_chain.sv
// Testbench for axi_chan_slice_chain: four instances share one upstream source and
// one downstream ready; each has its own scoreboard queue.
//   0: SPILL, 2 cuts   1: SPILL, 3 cuts   2: FWD, 1 cut   3: BYPASS
module tb_axi_chan_slice_chain;
    import axi_slice_pkg::*;

    localparam int DW   = 16;
    localparam int NDUT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          validI;
    logic          readyI;
    logic [DW-1:0] dataI;

    logic          rO    [NDUT];
    logic          vO    [NDUT];
    logic [DW-1:0] dO    [NDUT];
    logic [3:0]    occ   [NDUT];
    logic          idleO [NDUT];

    logic [DW-1:0] sbq [NDUT][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Each instance gets a scoreboard monitor sampling on the falling edge, where
    // inputs and combinational outputs are settled for the coming rising edge.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam slice_mode_e M = (g == 3) ? SLICE_BYPASS : ((g == 2) ? SLICE_FWD : SLICE_SPILL);
        localparam int          N = (g == 1) ? 3 : ((g == 2) ? 1 : 2);
        localparam int          W = occ_width(N);
        localparam logic        CHK_STABLE = (g != 3);

        logic          rLoc;
        logic          vLoc;
        logic [DW-1:0] dLoc;
        logic [W-1:0]  occW;
        logic          idleLoc;
        logic          holdV;
        logic [DW-1:0] holdD;
        logic [3:0]    prevOcc;
        logic [DW-1:0] expD;
        int            step;

        axi_chan_slice_chain #(
            .DATA_WIDTH(DW),
            .NUM_CUTS  (N),
            .MODE      (M)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .valid_i    (validI),
            .ready_o    (rLoc),
            .data_i     (dataI),
            .valid_o    (vLoc),
            .ready_i    (readyI),
            .data_o     (dLoc),
            .occupancy_o(occW),
            .idle_o     (idleLoc)
        );

        assign rO[g]    = rLoc;
        assign vO[g]    = vLoc;
        assign dO[g]    = dLoc;
        assign occ[g]   = 4'(occW);
        assign idleO[g] = idleLoc;

        always @(negedge clk) begin
            if (rst) begin
                sbq[g].delete();
                holdV   = 1'b0;
                prevOcc = 4'd0;
            end else begin
                if (holdV) begin
                    checks++;
                    if (vLoc !== 1'b1 || dLoc !== holdD) begin
                        errors++;
                        $display("[TB] FAIL stable[%0d]: valid_o=%b data_o=%h, required valid_o=1 data_o=%h", g, vLoc, dLoc, holdD);
                    end
                end
                step = int'(occ[g]) - int'(prevOcc);
                checks++;
                if (step > 1 || step < -1) begin
                    errors++;
                    $display("[TB] FAIL occStep[%0d]: occupancy %0d -> %0d, required change of at most 1", g, prevOcc, occ[g]);
                end
                if (validI && rLoc) begin
                    sbq[g].push_back(dataI);
                end
                if (vLoc && readyI) begin
                    checks++;
                    if (sbq[g].size() == 0) begin
                        errors++;
                        $display("[TB] FAIL order[%0d]: got beat %h, required no beat (scoreboard empty)", g, dLoc);
                    end else begin
                        expD = sbq[g].pop_front();
                        if (dLoc !== expD) begin
                            errors++;
                            $display("[TB] FAIL order[%0d]: got %h, required %h", g, dLoc, expD);
                        end
                    end
                end
                holdV   = CHK_STABLE && vLoc && !readyI;
                holdD   = dLoc;
                prevOcc = occ[g];
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r);
        validI = v;
        dataI  = d;
        readyI = r;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            applyStimulus(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b1, DW'(16'h0055), 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (rO[0] !== 1'b0 || vO[0] !== 1'b0 || occ[0] !== 4'd0 || idleO[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL resetState: ready_o=%b valid_o=%b occ=%0d idle=%b, required 0 0 0 1", rO[0], vO[0], occ[0], idleO[0]);
        end
        checks++;
        if (rO[3] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL resetBypassReady: ready_o=%b, required 0", rO[3]);
        end
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rO[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL releaseReady: ready_o=%b, required 1", rO[0]);
        end
    endtask

    task automatic test_streaming();
        for (int c = 0; c < 10; c++) begin
            nextCycle();
            applyStimulus(c < 8, DW'(c + 1), 1'b1);
            @(negedge clk);
            if (c >= 2) begin
                checks++;
                if (vO[0] !== 1'b1 || dO[0] !== DW'(c - 1)) begin
                    errors++;
                    $display("[TB] FAIL stream c=%0d: valid_o=%b data_o=%h, required 1 %h", c, vO[0], dO[0], DW'(c - 1));
                end
            end
            if (c >= 2 && c <= 8) begin
                checks++;
                if (occ[0] !== 4'd2) begin
                    errors++;
                    $display("[TB] FAIL streamOcc c=%0d: occ=%0d, required 2", c, occ[0]);
                end
            end
        end
        drain(8);
    endtask

    task automatic test_backpressure();
        int            accepted;
        logic [DW-1:0] got[$];
        accepted = 0;
        for (int n = 0; n < 10; n++) begin
            nextCycle();
            applyStimulus(1'b1, DW'(16'h0010 + n), 1'b0);
            @(negedge clk);
            if (!rO[0]) break;
            accepted++;
        end
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (accepted != 4 || occ[0] !== 4'd4 || rO[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bpFill: accepted=%0d occ=%0d ready_o=%b, required 4 4 0", accepted, occ[0], rO[0]);
        end
        for (int n = 0; n < 12; n++) begin
            nextCycle();
            applyStimulus(1'b0, '0, 1'b1);
            @(negedge clk);
            if (vO[0]) got.push_back(dO[0]);
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("[TB] FAIL bpDrainCount: drained %0d, required 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== DW'(16'h0010 + i)) begin
                    errors++;
                    $display("[TB] FAIL bpDrain[%0d]: got %h, required %h", i, got[i], DW'(16'h0010 + i));
                end
            end
        end
        checks++;
        if (idleO[0] !== 1'b1 || occ[0] !== 4'd0) begin
            errors++;
            $display("[TB] FAIL bpIdle: idle=%b occ=%0d, required 1 0", idleO[0], occ[0]);
        end
    endtask

    task automatic test_fwd_simultaneous();
        nextCycle();
        applyStimulus(1'b1, DW'(16'h0021), 1'b0);
        nextCycle();
        applyStimulus(1'b1, DW'(16'h0022), 1'b0);
        @(negedge clk);
        checks++;
        if (occ[2] !== 4'd1 || rO[2] !== 1'b0 || vO[2] !== 1'b1 || dO[2] !== DW'(16'h0021)) begin
            errors++;
            $display("[TB] FAIL fwdFull: occ=%0d ready_o=%b valid_o=%b data_o=%h, required 1 0 1 0021", occ[2], rO[2], vO[2], dO[2]);
        end
        nextCycle();
        applyStimulus(1'b1, DW'(16'h0022), 1'b1);
        @(negedge clk);
        checks++;
        if (rO[2] !== 1'b1 || occ[2] !== 4'd1) begin
            errors++;
            $display("[TB] FAIL fwdPassReady: ready_o=%b occ=%0d, required 1 1", rO[2], occ[2]);
        end
        nextCycle();
        applyStimulus(1'b1, DW'(16'h0023), 1'b1);
        @(negedge clk);
        checks++;
        if (occ[2] !== 4'd1 || vO[2] !== 1'b1 || dO[2] !== DW'(16'h0022)) begin
            errors++;
            $display("[TB] FAIL fwdNoBubble1: occ=%0d valid_o=%b data_o=%h, required 1 1 0022", occ[2], vO[2], dO[2]);
        end
        nextCycle();
        applyStimulus(1'b0, '0, 1'b1);
        @(negedge clk);
        checks++;
        if (occ[2] !== 4'd1 || vO[2] !== 1'b1 || dO[2] !== DW'(16'h0023)) begin
            errors++;
            $display("[TB] FAIL fwdNoBubble2: occ=%0d valid_o=%b data_o=%h, required 1 1 0023", occ[2], vO[2], dO[2]);
        end
        drain(10);
    endtask

    task automatic test_bypass();
        for (int i = 0; i < 20; i++) begin
            nextCycle();
            applyStimulus(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
            @(negedge clk);
            checks++;
            if (vO[3] !== validI || dO[3] !== dataI || rO[3] !== readyI || occ[3] !== 4'd0 || idleO[3] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL bypass: v=%b d=%h r=%b occ=%0d idle=%b, required v=%b d=%h r=%b occ=0 idle=1",
                         vO[3], dO[3], rO[3], occ[3], idleO[3], validI, dataI, readyI);
            end
        end
        drain(12);
    endtask

    task automatic test_reset_mid();
        int accepted;
        accepted = 0;
        for (int n = 0; n < 12 && accepted < 5; n++) begin
            nextCycle();
            applyStimulus(1'b1, DW'(16'h0030 + n), 1'b0);
            @(negedge clk);
            if (rO[1]) accepted++;
        end
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0);
        @(negedge clk);
        checks++;
        if (occ[1] !== 4'd5 || vO[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midHeld: occ=%0d valid_o=%b, required 5 1", occ[1], vO[1]);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (vO[1] !== 1'b0 || occ[1] !== 4'd0 || idleO[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midAsync: valid_o=%b occ=%0d idle=%b, required 0 0 1", vO[1], occ[1], idleO[1]);
        end
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b1, DW'(16'h00AB), 1'b1);
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            nextCycle();
            applyStimulus(1'b0, '0, 1'b1);
            @(negedge clk);
            checks++;
            if (c < 3) begin
                if (vO[1] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL midLatency c=%0d: valid_o=%b, required 0", c, vO[1]);
                end
            end else if (vO[1] !== 1'b1 || dO[1] !== DW'(16'h00AB)) begin
                errors++;
                $display("[TB] FAIL midBeat: valid_o=%b data_o=%h, required 1 00ab", vO[1], dO[1]);
            end
        end
        drain(10);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            nextCycle();
            applyStimulus($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0);
        end
        drain(16);
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            checks++;
            if (sbq[g].size() != 0) begin
                errors++;
                $display("[TB] FAIL randomDrained[%0d]: %0d beats outstanding, required 0", g, sbq[g].size());
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_fwd_simultaneous();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
